// File: rtl/iot_pkg.sv
// Shared types and constants for the PDP-8/I IOT pulse sequencer.
// Imported by the sequencer, its slot timer and the bus interface.
package iot_pkg;

  localparam int IOP1 = 0;
  localparam int IOP2 = 1;
  localparam int IOP4 = 2;
  localparam int AC_W = 12;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SETUP,
    S_P1,
    S_G1,
    S_P2,
    S_G2,
    S_P4,
    S_G4,
    S_DONE
  } state_e;

  typedef struct packed {
    logic            skip;
    logic            clr;
    logic            load;
    logic [AC_W-1:0] data;
  } iot_res_t;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/iot_sequencer_if.sv
// IOT bus bundle: decode-side request, device return lines,
// IOP pulses and the consolidated result.
interface iot_sequencer_if;
  import iot_pkg::*;

  logic            iot_start;
  logic [2:0]      iop_en;
  logic            io_skip;
  logic            io_ac_clear;
  logic            io_ac_load;
  logic [AC_W-1:0] io_data;
  logic            iop1;
  logic            iop2;
  logic            iop4;
  logic            busy;
  logic            done;
  logic            skip_out;
  logic            ac_clr_out;
  logic            ac_load_out;
  logic [AC_W-1:0] ac_data;

  modport slave (
    input  iot_start, iop_en,
    input  io_skip, io_ac_clear,
    input  io_ac_load, io_data,
    output iop1, iop2, iop4,
    output busy, done,
    output skip_out, ac_clr_out,
    output ac_load_out, ac_data
  );

  modport master (
    output iot_start, iop_en,
    output io_skip, io_ac_clear,
    output io_ac_load, io_data,
    input  iop1, iop2, iop4,
    input  busy, done,
    input  skip_out, ac_clr_out,
    input  ac_load_out, ac_data
  );

endinterface

// File: rtl/iot_slot_timer.sv
// Loadable down-counter; tc is high while the count sits at zero,
// i.e. on the last cycle of the slot it was loaded for.
module iot_slot_timer #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          tc
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/iot_sequencer.sv
// PDP-8/I IOT sequencer: fixed-length IOP1/IOP2/IOP4 pulse train,
// samples device returns on the last cycle of each enabled pulse.
module iot_sequencer
  import iot_pkg::*;
#(
  parameter int SETUP_W = 2,
  parameter int PULSE_W = 4,
  parameter int GAP_W   = 2
) (
  input logic           clk,
  input logic           rst_n,
  iot_sequencer_if.slave bus
);

  localparam int CW =
    $clog2(max3(SETUP_W, PULSE_W, GAP_W)) + 1;
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_W - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_W - 1);

  state_e        state_q, state_d;
  logic [2:0]    en_q, en_d;
  logic [2:0]    iop_q, iop_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  iot_res_t      acc_q, acc_d;
  logic          tmr_ld;
  logic [CW-1:0] tmr_val;
  logic          tc;
  logic          samp;
  logic          accept;

  iot_slot_timer #(.CW(CW)) u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_ld),
    .load_val (tmr_val),
    .tc       (tc)
  );

  assign accept = (state_q == S_IDLE) && bus.iot_start;

  always_comb begin
    state_d = state_q;
    tmr_ld  = 1'b0;
    tmr_val = '0;
    samp    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.iot_start) begin
          state_d = S_SETUP;
          tmr_ld  = 1'b1;
          tmr_val = SETUP_LD;
        end
      end
      S_SETUP: begin
        if (tc) begin
          state_d = S_P1;
          tmr_ld  = 1'b1;
          tmr_val = PULSE_LD;
        end
      end
      S_P1: begin
        samp = tc & en_q[IOP1];
        if (tc) begin
          state_d = S_G1;
          tmr_ld  = 1'b1;
          tmr_val = GAP_LD;
        end
      end
      S_G1: begin
        if (tc) begin
          state_d = S_P2;
          tmr_ld  = 1'b1;
          tmr_val = PULSE_LD;
        end
      end
      S_P2: begin
        samp = tc & en_q[IOP2];
        if (tc) begin
          state_d = S_G2;
          tmr_ld  = 1'b1;
          tmr_val = GAP_LD;
        end
      end
      S_G2: begin
        if (tc) begin
          state_d = S_P4;
          tmr_ld  = 1'b1;
          tmr_val = PULSE_LD;
        end
      end
      S_P4: begin
        samp = tc & en_q[IOP4];
        if (tc) begin
          state_d = S_G4;
          tmr_ld  = 1'b1;
          tmr_val = GAP_LD;
        end
      end
      S_G4: begin
        if (tc) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Accumulators clear on accept so a stale result never leaks.
  always_comb begin
    en_d  = en_q;
    acc_d = acc_q;
    if (accept) begin
      en_d  = bus.iop_en;
      acc_d = '0;
    end else if (samp) begin
      acc_d.skip = acc_q.skip | bus.io_skip;
      acc_d.clr  = acc_q.clr  | bus.io_ac_clear;
      acc_d.load = acc_q.load | bus.io_ac_load;
      if (bus.io_ac_load) begin
        acc_d.data = acc_q.data | bus.io_data;
      end
    end
  end

  // Outputs registered from next state so pulses are glitch-free.
  always_comb begin
    iop_d       = '0;
    iop_d[IOP1] = (state_d == S_P1) & en_d[IOP1];
    iop_d[IOP2] = (state_d == S_P2) & en_d[IOP2];
    iop_d[IOP4] = (state_d == S_P4) & en_d[IOP4];
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      en_q    <= '0;
      iop_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      iop_q   <= iop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.iop1        = iop_q[IOP1];
  assign bus.iop2        = iop_q[IOP2];
  assign bus.iop4        = iop_q[IOP4];
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.skip_out    = done_q & acc_q.skip;
  assign bus.ac_clr_out  = done_q & acc_q.clr;
  assign bus.ac_load_out = done_q & acc_q.load;
  assign bus.ac_data     = acc_q.data & {AC_W{done_q}};

endmodule

// File: tb/tb_iot_sequencer.sv
// Scoreboard bench for iot_sequencer: per-cycle pulse timing plus
// queued expected results compared when done fires.
module tb_iot_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  iot_sequencer_if bus();

  iot_sequencer #(
    .SETUP_W (2),
    .PULSE_W (4),
    .GAP_W   (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        skip;
    logic        clr;
    logic        load;
    logic [11:0] data;
  } res_t;

  res_t        sbq[$];
  res_t        mon_e;
  int          n_chk = 0;
  int          n_err = 0;
  int          n_done = 0;
  logic        s_skip [24];
  logic        s_clr  [24];
  logic        s_ld   [24];
  logic [11:0] s_dat  [24];

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      n_done++;
      if (sbq.size() == 0) begin
        chk("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("skip_out", 32'(bus.skip_out), 32'(mon_e.skip));
        chk("ac_clr_out", 32'(bus.ac_clr_out), 32'(mon_e.clr));
        chk("ac_load_out", 32'(bus.ac_load_out), 32'(mon_e.load));
        chk("ac_data", 32'(bus.ac_data), 32'(mon_e.data));
      end
    end
  end

  function automatic logic in_pulse(
    input logic en_bit,
    input int   k,
    input int   lo
  );
    return en_bit && (k >= lo) && (k <= lo + 3);
  endfunction

  task automatic all_zero(input string tag);
    chk({tag, "_iops"}, 32'({bus.iop1, bus.iop2, bus.iop4}), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_res"},
        32'({bus.skip_out, bus.ac_clr_out,
             bus.ac_load_out, bus.ac_data}), 32'd0);
  endtask

  task automatic zero_inputs;
    bus.iot_start   = 1'b0;
    bus.iop_en      = 3'b000;
    bus.io_skip     = 1'b0;
    bus.io_ac_clear = 1'b0;
    bus.io_ac_load  = 1'b0;
    bus.io_data     = 12'o0000;
  endtask

  // mode: 0 quiet, 1 load 5252 held, 2 mixed P1/P2/P4,
  // 3 skip at k=4, 4 skip at k=6, 5 extra starts, 6 random
  task automatic run(
    input logic [2:0] en,
    input int         mode,
    input int         rst_at
  );
    res_t e;
    int   d0;
    int   ks;
    for (int k = 0; k < 24; k++) begin
      s_skip[k] = 1'b0;
      s_clr[k]  = 1'b0;
      s_ld[k]   = 1'b0;
      s_dat[k]  = 12'o0000;
      if (mode == 1) begin
        s_ld[k]  = 1'b1;
        s_dat[k] = 12'o5252;
      end
      if (mode == 6) begin
        s_skip[k] = ($urandom_range(0, 3) == 0);
        s_clr[k]  = ($urandom_range(0, 3) == 0);
        s_ld[k]   = ($urandom_range(0, 1) == 0);
        s_dat[k]  = 12'($urandom_range(0, 4095));
      end
    end
    if (mode == 2) begin
      s_ld[6]   = 1'b1;
      s_dat[6]  = 12'o0007;
      s_ld[18]  = 1'b1;
      s_dat[18] = 12'o7000;
      for (int k = 9; k <= 12; k++) s_skip[k] = 1'b1;
    end
    if (mode == 3) s_skip[4] = 1'b1;
    if (mode == 4) s_skip[6] = 1'b1;

    e = '0;
    for (int p = 0; p < 3; p++) begin
      if (en[p]) begin
        ks = 6 + 6 * p;
        e.skip = e.skip | s_skip[ks];
        e.clr  = e.clr  | s_clr[ks];
        e.load = e.load | s_ld[ks];
        if (s_ld[ks]) e.data = e.data | s_dat[ks];
      end
    end
    if (rst_at < 0) sbq.push_back(e);
    d0 = n_done;

    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      chk($sformatf("busy@%0d", k), 32'(bus.busy),
          32'(k >= 1 && k <= 21));
      chk($sformatf("done@%0d", k), 32'(bus.done),
          32'(k == 21));
      chk($sformatf("iop1@%0d", k), 32'(bus.iop1),
          32'(in_pulse(en[0], k, 3)));
      chk($sformatf("iop2@%0d", k), 32'(bus.iop2),
          32'(in_pulse(en[1], k, 9)));
      chk($sformatf("iop4@%0d", k), 32'(bus.iop4),
          32'(in_pulse(en[2], k, 15)));
      if (k == 22) all_zero("idle_after_done");
      bus.iot_start = (k == 0) ||
        (mode == 5 && (k == 10 || k == 21));
      bus.iop_en      = (k == 0) ? en : ~en;
      bus.io_skip     = s_skip[k];
      bus.io_ac_clear = s_clr[k];
      bus.io_ac_load  = s_ld[k];
      bus.io_data     = s_dat[k];
      if (k == rst_at) begin
        #1 rst_n = 1'b0;
        #1 all_zero("async_rst");
        @(negedge clk);
        zero_inputs();
        rst_n = 1'b1;
        break;
      end
    end
    zero_inputs();
    if (rst_at >= 0) repeat (24) @(negedge clk);
    @(negedge clk);
    chk("done_count", 32'(n_done - d0),
        32'((rst_at < 0) ? 1 : 0));
  endtask

  initial begin
    zero_inputs();
    #12;
    all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    all_zero("post_reset");

    run(3'b111, 0, -1);
    run(3'b010, 1, -1);
    run(3'b101, 2, -1);
    run(3'b001, 3, -1);
    run(3'b001, 4, -1);
    run(3'b111, 5, -1);
    run(3'b111, 0, 11);
    run(3'b111, 0, -1);
    for (int i = 0; i < 4; i++) begin
      run(3'($urandom_range(0, 7)), 6, -1);
    end
    run(3'b000, 6, -1);

    chk("sb_left", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
